fifo_sync_prog: RTL

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

---
 rtl/fifo_sync_prog.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with first-word fall-through head register, programmable almost-full/empty
// flags and overflow/underflow pulses. Define FIFO_SYNC_PROG_HWM_EN to build the high-water mark.
module fifo_sync_prog #(
  parameter int unsigned ADDRWIDTH = 5,
  parameter int unsigned DATAWIDTH = 18
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   af_thresh,
  input  logic [ADDRWIDTH:0]   ae_thresh,
  output logic [DATAWIDTH-1:0] rd_data,
  input  logic                 re,
  output logic                 ne,
  output logic                 cf,
  output logic                 af,
  output logic                 ae,
  output logic [ADDRWIDTH:0]   count,
  output logic                 ovf,
  output logic                 unf,
  output logic [ADDRWIDTH:0]   hwm,
  input  logic                 hwm_clr
);

  localparam int unsigned DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] DepthC = (ADDRWIDTH + 1)'(DEPTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDRWIDTH:0]   count_q, count_d;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic                 ne_q, ne_d, cf_q, cf_d, af_q, af_d, ae_q, ae_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic                 init_q;
  logic                 wr_acc, rd_acc;

  always_comb begin
    rd_acc    = re & ne_q & ~flush;
    wr_acc    = we & ~flush & (~cf_q | rd_acc);
    wr_ptr_d  = wr_ptr_q + ADDRWIDTH'(wr_acc);
    rd_ptr_d  = rd_ptr_q + ADDRWIDTH'(rd_acc);
    count_d   = count_q + (ADDRWIDTH + 1)'(wr_acc) - (ADDRWIDTH + 1)'(rd_acc);
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (wr_acc && (count_q == (ADDRWIDTH + 1)'(rd_acc))) begin
      // Effectively empty this cycle: the incoming word becomes the head directly.
      rd_data_d = wr_data;
    end else if (count_d != '0) begin
      rd_data_d = mem_q[rd_ptr_d];
    end
    ne_d  = (count_d != '0);
    cf_d  = (count_d == DepthC);
    af_d  = (count_d >= af_thresh);
    ae_d  = (count_d <= ae_thresh);
    ovf_d = we & ~flush & ~wr_acc;
    unf_d = re & ~flush & ~rd_acc;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      ne_q      <= 1'b0;
      cf_q      <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      init_q    <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      ne_q      <= ne_d;
      cf_q      <= cf_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      init_q    <= 1'b0;
    end
  end

  // Until the first edge after reset, af tracks the live threshold against an empty FIFO.
  assign af      = init_q ? (af_thresh == '0) : af_q;
  assign rd_data = rd_data_q;
  assign ne      = ne_q;
  assign cf      = cf_q;
  assign ae      = ae_q;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

`ifdef FIFO_SYNC_PROG_HWM_EN
  logic [ADDRWIDTH:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) hwm_d = count_d;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) hwm_q <= '0;
    else          hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  logic unused_hwm_clr;
  assign unused_hwm_clr = hwm_clr;
  assign hwm = '0;
`endif

endmodule
